rv32i_mem_arbiter: RTL and testbench

- Single-port memory arbiter/sequencer shared by the instruction-fetch path and the load/store path of the rv32i core.
- Accepts one request at a time over valid/ready handshakes and drives a fixed-latency, word-wide, byte-strobed synchronous memory.
- Returns a single-cycle response pulse to the requester that owns the transaction.
- Load/store has priority over fetch, with a starvation guard for fetch.

---
 rtl/rv32i_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter
//   Single-port memory sequencer shared by the instruction-fetch path (if_*)
//   and the load/store path (dm_*). It accepts one request at a time over a
//   valid/ready handshake and drives a fixed-latency synchronous memory
//   (mem_*). The owner of the transaction gets a one-cycle response pulse.
//   Load/store wins arbitration, except that fetch wins once it has lost
//   STARVE_MAX consecutive contended arbitrations.
//
// Parameters
//   MEM_LAT    : cycles from the mem_en cycle to valid mem_rdata (1..4)
//   STARVE_MAX : contended fetch losses before fetch is forced through (1..15)
//
// Ports
//   clk, reset                      : rising-edge clock, sync active-low reset
//   if_req_valid/ready, if_addr     : fetch request handshake and byte address
//   if_rsp_valid, if_rsp_data       : fetch response pulse and instruction word
//   dm_req_valid/ready, dm_addr,
//   dm_we, dm_wdata, dm_wstrb       : load/store request
//   dm_rsp_valid, dm_rsp_data       : load data / store ack (data 0 on ack)
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata            : synchronous memory port (word address)
//   busy                            : transaction in flight
module rv32i_mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        dm_req_valid,
  output logic        dm_req_ready,
  input  logic [31:0] dm_addr,
  input  logic        dm_we,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic        dm_rsp_valid,
  output logic [31:0] dm_rsp_data,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [2:0] LAT_LD     = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  wait_cnt;
  logic [3:0]  starve_cnt;
  logic        owner_dm;
  logic        is_store;
  logic        grant_if;
  logic        grant_dm;
  logic        accept;
  logic        last_wait;

  // Arbitration and next state. Ready is a combinational function of the
  // valids while idle; nothing is granted outside IDLE.
  always_comb begin
    state_nxt    = state;
    grant_if     = 1'b0;
    grant_dm     = 1'b0;
    if_req_ready = 1'b0;
    dm_req_ready = 1'b0;
    case (state)
      S_IDLE: begin
        grant_dm     = dm_req_valid && !(if_req_valid && (starve_cnt == STARVE_LIM));
        grant_if     = if_req_valid && !grant_dm;
        if_req_ready = grant_if;
        dm_req_ready = grant_dm;
        if (grant_if || grant_dm) begin
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: state_nxt = S_WAIT;
      S_WAIT: begin
        if (wait_cnt == 3'd1) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept    = grant_if || grant_dm;
  assign last_wait = (state == S_WAIT) && (wait_cnt == 3'd1);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Starvation guard: counts contended IDLE cycles that fetch lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (!if_req_valid || grant_if) begin
        starve_cnt <= '0;
      end else if (grant_dm && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Memory latency counter: loaded on the way out of ACCESS, the read data
  // is valid in the cycle where it reaches 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == S_ACCESS) begin
      wait_cnt <= LAT_LD;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

  // Handshake capture -> ACCESS: the request is registered straight into the
  // memory port so mem_en/mem_we are live for exactly the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_dm  <= 1'b0;
      is_store  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= accept;
      mem_we <= (grant_dm && dm_we) ? dm_wstrb : 4'b0000;
      if (accept) begin
        owner_dm  <= grant_dm;
        is_store  <= grant_dm && dm_we;
        mem_addr  <= (grant_dm ? dm_addr : if_addr) & 32'hFFFF_FFFC;
        mem_wdata <= grant_dm ? dm_wdata : 32'h0;
      end
    end
  end

  // Last WAIT cycle -> response: read data is registered into the owner's
  // response, the other requester's data register holds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_rsp_valid <= 1'b0;
      dm_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      dm_rsp_data  <= '0;
    end else begin
      if_rsp_valid <= last_wait && !owner_dm;
      dm_rsp_valid <= last_wait && owner_dm;
      if (last_wait && !owner_dm) begin
        if_rsp_data <= mem_rdata;
      end
      if (last_wait && owner_dm) begin
        dm_rsp_data <= is_store ? 32'h0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Testbench for rv32i_mem_arbiter: directed table of single transactions,
// hand-written multi-cycle sequences, and a randomized run against a
// transaction-level reference model.
module tb_rv32i_mem_arbiter;

  localparam int LAT1   = 1;
  localparam int LAT3   = 3;
  localparam int STARVE = 4;
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_addr, if_rsp_data;
  logic        dm_req_valid, dm_req_ready, dm_we, dm_rsp_valid;
  logic [31:0] dm_addr, dm_wdata, dm_rsp_data;
  logic [3:0]  dm_wstrb;
  logic        mem_en, busy;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        if_req_valid_3, if_req_ready_3, if_rsp_valid_3;
  logic [31:0] if_addr_3, if_rsp_data_3;
  logic        dm_req_valid_3, dm_req_ready_3, dm_we_3, dm_rsp_valid_3;
  logic [31:0] dm_addr_3, dm_wdata_3, dm_rsp_data_3;
  logic [3:0]  dm_wstrb_3;
  logic        mem_en_3, busy_3;
  logic [3:0]  mem_we_3;
  logic [31:0] mem_addr_3, mem_wdata_3, mem_rdata_3;

  rv32i_mem_arbiter #(.MEM_LAT(LAT1), .STARVE_MAX(STARVE)) u_dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_addr(dm_addr),
    .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  rv32i_mem_arbiter #(.MEM_LAT(LAT3), .STARVE_MAX(STARVE)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid_3), .if_req_ready(if_req_ready_3), .if_addr(if_addr_3),
    .if_rsp_valid(if_rsp_valid_3), .if_rsp_data(if_rsp_data_3),
    .dm_req_valid(dm_req_valid_3), .dm_req_ready(dm_req_ready_3), .dm_addr(dm_addr_3),
    .dm_we(dm_we_3), .dm_wdata(dm_wdata_3), .dm_wstrb(dm_wstrb_3),
    .dm_rsp_valid(dm_rsp_valid_3), .dm_rsp_data(dm_rsp_data_3),
    .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata_3), .busy(busy_3)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [31:0] init_word(input logic [9:0] idx);
    case (idx)
      10'd16:  return 32'h0000_0013;
      10'd65:  return 32'hDEAD_BEEF;
      10'd128: return 32'hAABB_CCDD;
      default: return {6'h2A, idx, 6'h15, idx};
    endcase
  endfunction

  // Memory for the MEM_LAT=1 instance: byte-strobed writes, 1-cycle read.
  logic [31:0] tmem [0:1023];
  logic [31:0] rdata_q1;
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 1024; i++) tmem[i] <= init_word(i[9:0]);
      rdata_q1 <= BAD;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) tmem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      rdata_q1 <= tmem[mem_addr[11:2]];
    end else begin
      rdata_q1 <= BAD;
    end
  end
  assign mem_rdata = rdata_q1;

  // Read-only memory for the MEM_LAT=3 instance.
  logic [31:0] p3a, p3b, p3c;
  always @(posedge clk) begin
    p3a <= mem_en_3 ? init_word(mem_addr_3[11:2]) : BAD;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign mem_rdata_3 = p3c;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_addr;
    logic [3:0]  exp_we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [9];

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic do_txn(input vec_t v, input string nm);
    int a;
    bit got;
    @(posedge clk); #1;
    if (v.fetch) begin
      if_req_valid = 1'b1; if_addr = v.addr;
    end else begin
      dm_req_valid = 1'b1; dm_addr = v.addr; dm_we = v.we;
      dm_wdata = v.wdata; dm_wstrb = v.wstrb;
    end
    @(negedge clk);
    a = cyc;
    check({nm, " if_ready"}, if_req_ready, v.fetch);
    check({nm, " dm_ready"}, dm_req_ready, !v.fetch);
    @(posedge clk); #1;
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
    @(negedge clk);
    check({nm, " mem_en"}, mem_en, 1);
    check({nm, " mem_addr"}, mem_addr, v.exp_addr);
    check({nm, " mem_we"}, mem_we, v.exp_we);
    if (v.we && !v.fetch) check({nm, " mem_wdata"}, mem_wdata, v.wdata);
    check({nm, " busy"}, busy, 1);
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if ((v.fetch ? if_rsp_valid : dm_rsp_valid) === 1'b1) got = 1'b1;
    end
    check({nm, " rsp_seen"}, got, 1);
    if (got) begin
      check({nm, " latency"}, 32'(cyc - a), 32'(LAT1 + 2));
      check({nm, " rsp_data"}, v.fetch ? if_rsp_data : dm_rsp_data, v.exp_data);
      check({nm, " other_rsp"}, v.fetch ? dm_rsp_valid : if_rsp_valid, 0);
      @(negedge clk);
      check({nm, " pulse_end"}, v.fetch ? if_rsp_valid : dm_rsp_valid, 0);
    end
  endtask

  // Reference model state for the random run.
  logic [31:0] refmem [0:1023];
  int          next_free, g_cyc, starve, c;
  bit          g_dm, gi, gd, idle, exp_en;
  logic [31:0] g_addr, g_wdata, g_rsp, exp_if_data, exp_dm_data;
  logic [3:0]  g_we;
  logic [9:0]  widx;

  initial begin
    int a, ng, both_cnt;
    int grants [10];
    bit got;

    tbl[0] = '{0, 0, 32'h0000_0104, 32'h0,         4'h0, 32'h104, 4'h0, 32'hDEAD_BEEF};
    tbl[1] = '{0, 1, 32'h0000_0203, 32'h1122_3344, 4'h3, 32'h200, 4'h3, 32'h0};
    tbl[2] = '{0, 0, 32'h0000_0200, 32'h0,         4'h0, 32'h200, 4'h0, 32'hAABB_3344};
    tbl[3] = '{1, 0, 32'h0000_0040, 32'h0,         4'h0, 32'h040, 4'h0, 32'h0000_0013};
    tbl[4] = '{1, 0, 32'h0000_0107, 32'h0,         4'h0, 32'h104, 4'h0, 32'hDEAD_BEEF};
    tbl[5] = '{0, 1, 32'h0000_0300, 32'hCAFE_F00D, 4'hF, 32'h300, 4'hF, 32'h0};
    tbl[6] = '{0, 1, 32'h0000_0301, 32'h0000_5A00, 4'h2, 32'h300, 4'h2, 32'h0};
    tbl[7] = '{0, 0, 32'h0000_0302, 32'h0,         4'h0, 32'h300, 4'h0, 32'hCAFE_5A0D};
    tbl[8] = '{1, 0, 32'h0000_0300, 32'h0,         4'h0, 32'h300, 4'h0, 32'hCAFE_5A0D};

    reset = 1'b0;
    if_req_valid = 0; if_addr = 0; dm_req_valid = 0; dm_addr = 0;
    dm_we = 0; dm_wdata = 0; dm_wstrb = 0;
    if_req_valid_3 = 0; if_addr_3 = 0; dm_req_valid_3 = 0; dm_addr_3 = 0;
    dm_we_3 = 0; dm_wdata_3 = 0; dm_wstrb_3 = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst mem_en", mem_en, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst if_rsp_valid", if_rsp_valid, 0);
    check("rst dm_rsp_valid", dm_rsp_valid, 0);
    check("rst if_rsp_data", if_rsp_data, 0);
    check("rst dm_rsp_data", dm_rsp_data, 0);
    check("rst busy", busy, 0);
    check("rst busy3", busy_3, 0);
    reset = 1'b1;

    // Directed single transactions
    for (int i = 0; i < 9; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

    // Contention: both valid continuously
    do_reset();
    @(posedge clk); #1;
    if_req_valid = 1; if_addr = 32'h40; dm_req_valid = 1; dm_addr = 32'h104; dm_we = 0;
    ng = 0; both_cnt = 0;
    for (int k = 0; k < 80 && ng < 10; k++) begin
      @(negedge clk);
      if (if_req_ready && dm_req_ready) both_cnt++;
      if (dm_req_ready) begin grants[ng] = 2; ng++; end
      else if (if_req_ready) begin grants[ng] = 1; ng++; end
    end
    @(posedge clk); #1;
    if_req_valid = 0; dm_req_valid = 0;
    check("contend grant_count", ng, 10);
    check("contend one_ready", both_cnt, 0);
    for (int i = 0; i < ng; i++)
      check($sformatf("contend grant%0d", i), grants[i],
            ((i % (STARVE + 1)) == STARVE) ? 1 : 2);
    repeat (6) @(negedge clk);

    // Latency sweep on the MEM_LAT=3 instance, back-to-back fetch
    @(posedge clk); #1;
    if_req_valid_3 = 1; if_addr_3 = 32'h40;
    @(negedge clk);
    check("lat3 ready A", if_req_ready_3, 1);
    check("lat3 dm_ready", dm_req_ready_3, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("lat3 mem_en A+%0d", k), mem_en_3, k == 1);
      check($sformatf("lat3 mem_we A+%0d", k), mem_we_3, 0);
      check($sformatf("lat3 ready A+%0d", k), if_req_ready_3, k == 5);
      check($sformatf("lat3 rsp A+%0d", k), if_rsp_valid_3, k == 5);
      check($sformatf("lat3 busy A+%0d", k), busy_3, k < 5);
      if (k == 1) check("lat3 mem_addr", mem_addr_3, 32'h40);
      if (k == 5) begin
        check("lat3 rsp_data", if_rsp_data_3, 32'h0000_0013);
        check("lat3 dm_rsp", dm_rsp_valid_3, 0);
      end
    end
    @(posedge clk); #1;
    if_req_valid_3 = 0;
    repeat (8) @(negedge clk);

    // Reset during WAIT of a load
    @(posedge clk); #1;
    dm_req_valid = 1; dm_we = 0; dm_addr = 32'h104;
    @(negedge clk);
    check("midrst ready", dm_req_ready, 1);
    @(posedge clk); #1;
    dm_req_valid = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst busy_wait", busy, 1);
    @(negedge clk);
    check("midrst dm_rsp", dm_rsp_valid, 0);
    check("midrst busy", busy, 0);
    check("midrst mem_en", mem_en, 0);
    check("midrst mem_we", mem_we, 0);
    check("midrst mem_addr", mem_addr, 0);
    check("midrst mem_wdata", mem_wdata, 0);
    check("midrst dm_data", dm_rsp_data, 0);
    check("midrst if_data", if_rsp_data, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst dm_rsp_after", dm_rsp_valid, 0);
    do_txn(tbl[0], "postrst");

    // Fetch valid raised during ACCESS of a load
    @(posedge clk); #1;
    dm_req_valid = 1; dm_we = 0; dm_addr = 32'h200;
    @(negedge clk);
    check("late ready dm", dm_req_ready, 1);
    a = cyc;
    @(posedge clk); #1;
    dm_req_valid = 0; if_req_valid = 1; if_addr = 32'h40;
    @(negedge clk);
    check("late if_ready A+1", if_req_ready, 0);
    @(negedge clk);
    check("late if_ready A+2", if_req_ready, 0);
    @(negedge clk);
    check("late if_ready A+3", if_req_ready, 1);
    check("late dm_rsp A+3", dm_rsp_valid, 1);
    check("late dm_data", dm_rsp_data, 32'hAABB_CCDD);
    @(posedge clk); #1;
    if_req_valid = 0;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (if_rsp_valid === 1'b1) got = 1'b1;
    end
    check("late if_rsp_seen", got, 1);
    check("late if_latency", 32'(cyc - a), 32'(3 + LAT1 + 2));
    check("late if_data", if_rsp_data, 32'h0000_0013);

    // Randomized run against the transaction-level model
    do_reset();
    for (int i = 0; i < 1024; i++) refmem[i] = init_word(i[9:0]);
    next_free = 0; g_cyc = -100; starve = 0; g_dm = 0;
    g_addr = 0; g_wdata = 0; g_rsp = 0; g_we = 0;
    exp_if_data = 0; exp_dm_data = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      c = cyc;
      check("rnd if_rsp_valid", if_rsp_valid, (c == g_cyc + LAT1 + 2) && !g_dm);
      check("rnd dm_rsp_valid", dm_rsp_valid, (c == g_cyc + LAT1 + 2) && g_dm);
      if (c == g_cyc + LAT1 + 2) begin
        if (g_dm) exp_dm_data = g_rsp;
        else exp_if_data = g_rsp;
      end
      check("rnd if_rsp_data", if_rsp_data, exp_if_data);
      check("rnd dm_rsp_data", dm_rsp_data, exp_dm_data);
      exp_en = (c == g_cyc + 1);
      check("rnd mem_en", mem_en, exp_en);
      check("rnd mem_we", mem_we, exp_en ? g_we : 4'h0);
      if (exp_en) begin
        check("rnd mem_addr", mem_addr, g_addr);
        if (g_we != 0) check("rnd mem_wdata", mem_wdata, g_wdata);
      end
      idle = (c >= next_free);
      check("rnd busy", busy, !idle);
      gi = 0; gd = 0;
      if (idle) begin
        if (if_req_valid && dm_req_valid) begin
          if (starve == STARVE) gi = 1; else gd = 1;
        end else if (if_req_valid) gi = 1;
        else if (dm_req_valid) gd = 1;
        if (!if_req_valid || gi) starve = 0;
        else if (gd && starve < STARVE) starve++;
      end
      check("rnd if_ready", if_req_ready, gi);
      check("rnd dm_ready", dm_req_ready, gd);
      if (gi || gd) begin
        g_cyc = c; g_dm = gd; next_free = c + LAT1 + 2;
        g_addr = (gd ? dm_addr : if_addr) & 32'hFFFF_FFFC;
        g_we = (gd && dm_we) ? dm_wstrb : 4'h0;
        g_wdata = dm_wdata;
        widx = g_addr[11:2];
        if (gd && dm_we) begin
          for (int b = 0; b < 4; b++)
            if (dm_wstrb[b]) refmem[widx][8*b +: 8] = dm_wdata[8*b +: 8];
          g_rsp = 0;
        end else begin
          g_rsp = refmem[widx];
        end
      end
      @(posedge clk); #1;
      if (gi || !if_req_valid) begin
        if_req_valid = ($urandom_range(0, 9) < 7);
        if_addr = {22'h0, 10'($urandom)};
      end
      if (gd || !dm_req_valid) begin
        dm_req_valid = ($urandom_range(0, 9) < 7);
        dm_addr = {22'h0, 10'($urandom)};
        dm_we = 1'($urandom);
        dm_wdata = $urandom;
        dm_wstrb = 4'($urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog timeout");
  end

endmodule
